// File: rtl/nibble_demux.sv
// Receive-side demux for a time-multiplexed 2-to-1 nibble link: reassembles {high, low} halves into one word with a valid/ready handshake.
// Build option NIBBLE_DEMUX_OVERWRITE_EN: on overrun the newest word replaces the held one (default: newest is dropped).
module nibble_demux #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cen,
    input  logic                 n_e,
    input  logic                 s,
    input  logic [WIDTH-1:0]     z,
    input  logic                 ready,
    output logic [2*WIDTH-1:0]   q,
    output logic                 valid,
    output logic                 overrun,
    output logic                 sync_err
);

    localparam int unsigned QW = 2 * WIDTH;

    localparam logic [0:0] ST_WAIT_LO = 1'b0;
    localparam logic [0:0] ST_HAVE_LO = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [QW-1:0]    q_q, q_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             sync_err_q, sync_err_d;

    logic             sample_c;
    logic             complete_c;
    logic [QW-1:0]    word_c;

    assign sample_c = cen & ~n_e;
    assign word_c   = {z, lo_q};

    // State and output registers; reset overrides every same-edge event.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_WAIT_LO;
            lo_q       <= '0;
            q_q        <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            q_q        <= q_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            sync_err_q <= sync_err_d;
        end
    end

    // Assembler next-state: low half arms, high half completes; a high half with no low half is a sync error.
    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        sync_err_d = 1'b0;
        complete_c = 1'b0;

        if (sample_c) begin
            case (state_q)
                ST_WAIT_LO: begin
                    if (!s) begin
                        lo_d    = z;
                        state_d = ST_HAVE_LO;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
                ST_HAVE_LO: begin
                    if (!s) begin
                        lo_d = z;
                    end else begin
                        complete_c = 1'b1;
                        state_d    = ST_WAIT_LO;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LO;
                end
            endcase
        end
    end

    // Output slot: a completion loads q when the slot is free or being drained this edge, otherwise it overruns.
    always_comb begin
        q_d       = q_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (complete_c) begin
            if (!valid_q || ready) begin
                q_d     = word_c;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
`ifdef NIBBLE_DEMUX_OVERWRITE_EN
                q_d       = word_c;
`else
                q_d       = q_q;
`endif
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    assign q        = q_q;
    assign valid    = valid_q;
    assign overrun  = overrun_q;
    assign sync_err = sync_err_q;

endmodule

// File: tb/tb_nibble_demux.sv
// Directed, table-driven bench for nibble_demux: each vector is one clock with hand-computed outputs after that edge.
module tb_nibble_demux;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned NVEC  = 28;

`ifdef NIBBLE_DEMUX_OVERWRITE_EN
    localparam logic [7:0] OVR_Q = 8'h34;
`else
    localparam logic [7:0] OVR_Q = 8'h12;
`endif

    typedef struct {
        logic       rst;
        logic       cen;
        logic       ne;
        logic       s;
        logic [3:0] z;
        logic       rdy;
        logic [7:0] eq;
        logic       ev;
        logic       eo;
        logic       es;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             cen;
    logic             n_e;
    logic             s;
    logic [WIDTH-1:0] z;
    logic             ready;
    logic [7:0]       q;
    logic             valid;
    logic             overrun;
    logic             sync_err;

    int n_vec;
    int n_err;

    vec_t tbl [NVEC];

    nibble_demux #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .cen      (cen),
        .n_e      (n_e),
        .s        (s),
        .z        (z),
        .ready    (ready),
        .q        (q),
        .valid    (valid),
        .overrun  (overrun),
        .sync_err (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic c, input logic ne, input logic sel,
                                input logic [3:0] zz, input logic rdy, input logic [7:0] eq,
                                input logic ev, input logic eo, input logic es);
        vec_t v;
        v.rst = rst; v.cen = c;  v.ne = ne; v.s  = sel; v.z  = zz;
        v.rdy = rdy; v.eq  = eq; v.ev = ev; v.eo = eo;  v.es = es;
        return v;
    endfunction

    // Drive on the falling edge, check #1 after the rising edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        reset = v.rst; cen = v.cen; n_e = v.ne; s = v.s; z = v.z; ready = v.rdy;
        @(posedge clk);
        #1;
        n_vec++;
        if (q !== v.eq) begin
            n_err++;
            $display("FAIL %s q: got %h expected %h", name, q, v.eq);
        end
        if (valid !== v.ev) begin
            n_err++;
            $display("FAIL %s valid: got %b expected %b", name, valid, v.ev);
        end
        if (overrun !== v.eo) begin
            n_err++;
            $display("FAIL %s overrun: got %b expected %b", name, overrun, v.eo);
        end
        if (sync_err !== v.es) begin
            n_err++;
            $display("FAIL %s sync_err: got %b expected %b", name, sync_err, v.es);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; cen = 1'b0; n_e = 1'b1; s = 1'b0; z = '0; ready = 1'b0;

        //                rst  cen  ne   s    z      rdy   q      v     o     se
        // basic word, then drain
        tbl[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        // high half first -> sync_err pulse, then recovery
        tbl[4]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 1'b0, 8'h21, 1'b1, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
        // latest low half wins
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h1, 1'b0, 8'h21, 1'b0, 1'b0, 1'b0);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 1'b0, 8'h21, 1'b0, 1'b0, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'hC, 1'b0, 8'hC7, 1'b1, 1'b0, 1'b0);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'hC7, 1'b0, 1'b0, 1'b0);
        // n_e gap mid-word keeps the low half
        tbl[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h9, 1'b0, 8'hC7, 1'b0, 1'b0, 1'b0);
        tbl[15] = mk(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 1'b0, 8'hC7, 1'b0, 1'b0, 1'b0);
        tbl[16] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'hC7, 1'b0, 1'b0, 1'b0);
        tbl[17] = mk(1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 8'hC7, 1'b0, 1'b0, 1'b0);
        tbl[18] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h4, 1'b0, 8'h49, 1'b1, 1'b0, 1'b0);
        tbl[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h49, 1'b0, 1'b0, 1'b0);
        // reset during the gap discards the low half
        tbl[20] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h9, 1'b0, 8'h49, 1'b0, 1'b0, 1'b0);
        tbl[21] = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[22] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tbl[23] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        // reset beats a same-edge completion
        tbl[24] = mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[25] = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tbl[26] = mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tbl[27] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < int'(NVEC); i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

        // Overrun: held word 12, second word 34 arrives with ready=0; overrun is sticky.
        apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h2, 1'b0, 8'h00,  1'b0, 1'b0, 1'b0), "ovr_lo1");
        apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 8'h12,  1'b1, 1'b0, 1'b0), "ovr_w1");
        apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 1'b0, 8'h12,  1'b1, 1'b0, 1'b0), "ovr_lo2");
        apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 1'b0, OVR_Q,  1'b1, 1'b1, 1'b0), "ovr_w2");
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, OVR_Q,  1'b0, 1'b1, 1'b0), "ovr_drain");
        apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h6, 1'b0, OVR_Q,  1'b0, 1'b1, 1'b0), "ovr_lo3");
        apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 8'h56,  1'b1, 1'b1, 1'b0), "ovr_w3");
        apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'h8, 1'b0, 8'h56,  1'b1, 1'b1, 1'b0), "ovr_lo4");
        // completion while the held word is consumed on the same edge
        apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 1'b1, 8'h78,  1'b1, 1'b1, 1'b0), "ovr_w4");
        apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'h78,  1'b0, 1'b1, 1'b0), "ovr_drain2");
        apply(mk(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 8'h00,  1'b0, 1'b0, 1'b0), "ovr_reset");

        // Stream 01, 02, 03 with cen every other clk and ready=1; consumption ignores cen.
        for (int w = 1; w <= 3; w++) begin
            apply(mk(1'b0, 1'b1, 1'b0, 1'b0, 4'(w), 1'b1, 8'(w - 1), 1'b0, 1'b0, 1'b0),
                  $sformatf("str%0d_lo", w));
            apply(mk(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 8'(w - 1), 1'b0, 1'b0, 1'b0),
                  $sformatf("str%0d_gap1", w));
            apply(mk(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 8'(w),     1'b1, 1'b0, 1'b0),
                  $sformatf("str%0d_hi", w));
            apply(mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 8'(w),     1'b0, 1'b0, 1'b0),
                  $sformatf("str%0d_gap2", w));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
